// File: rtl/guess_proto_pkg.sv
// CM guess protocol constants and responder state type, shared by the
// responder and the guessing initiator.
package guess_proto_pkg;

    localparam logic [7:0] START_BYTE        = 8'h01;
    localparam logic [7:0] BEGIN_GUESSING    = 8'h02;
    localparam logic [7:0] YES               = 8'h03;
    localparam logic [7:0] NO                = 8'h04;
    localparam logic [7:0] END_BYTE          = 8'h05;
    localparam logic [7:0] START_GUESS_RANGE = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_END,
        ST_WAIT_RELEASE,
        ST_TURNAROUND,
        ST_COMPARE,
        ST_REPLY
    } resp_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cm_bus_sync.sv
// Two-flop synchronisation of the MCU interconnect clock and the CM data bus
// into the CLK_50 domain, with single-cycle edge strobes.
module cm_bus_sync (
    input  logic       CLK_50,
    input  logic       RST_N,
    input  logic       CLK_inter,
    input  logic [7:0] cm_in,
    output logic [7:0] cm_data,
    output logic       inter_rise,
    output logic       inter_fall
);

    logic       sync0;
    logic       sync1;
    logic [7:0] cm_s0;
    logic [7:0] cm_s1;

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            cm_s0 <= '0;
            cm_s1 <= '0;
        end else begin
            sync0 <= CLK_inter;
            sync1 <= sync0;
            cm_s0 <= cm_in;
            cm_s1 <= cm_s0;
        end
    end

    assign inter_rise = sync0 & ~sync1;
    assign inter_fall = ~sync0 & sync1;
    assign cm_data    = cm_s1;

endmodule

// File: rtl/guess_responder.sv
// FPGA-side CM guess responder: receives a framed guess, compares it against
// the secret with a deliberately data-dependent early-exit delay, then replies.
module guess_responder
    import guess_proto_pkg::*;
#(
    parameter int unsigned CODE_LEN        = 4,
    parameter int unsigned CYCLES_PER_BYTE = 1000,
    parameter int unsigned TURN_CYCLES     = 8,
    parameter int unsigned REPLY_HOLD      = 16
) (
    input  logic                           CLK_50,
    input  logic                           RST_N,
    input  logic                           CLK_inter,
    inout  logic [7:0]                     CM,
    input  logic [8*CODE_LEN-1:0]          secret,
    output logic [8*CODE_LEN-1:0]          guess_out,
    output logic                           guess_valid,
    output logic                           match,
    output logic [$clog2(CODE_LEN+1)-1:0]  match_bytes,
    output logic                           reply_active,
    output logic                           frame_error
);

    localparam int unsigned IDXW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned MBW  = $clog2(CODE_LEN + 1);
    localparam int unsigned TW   = $clog2(max3(CYCLES_PER_BYTE, TURN_CYCLES, REPLY_HOLD) + 1);

    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(CODE_LEN - 1);
    localparam logic [TW-1:0]   TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0]   CPB_LAST  = TW'(CYCLES_PER_BYTE - 1);
    localparam logic [TW-1:0]   HOLD_LAST = TW'(REPLY_HOLD - 1);

    resp_state_t state;
    resp_state_t state_n;

    logic [7:0]                cm_data;
    logic                      inter_rise;
    logic                      inter_fall;
    logic [IDXW-1:0]           idx;
    logic [IDXW-1:0]           cidx;
    logic [TW-1:0]             timer;
    logic [CODE_LEN-1:0][7:0]  shadow;
    logic [CODE_LEN-1:0][7:0]  guess_arr;
    logic [CODE_LEN-1:0][7:0]  secret_arr;
    logic [7:0]                reply_byte;
    logic                      byte_ne;

    cm_bus_sync u_sync (
        .CLK_50     (CLK_50),
        .RST_N      (RST_N),
        .CLK_inter  (CLK_inter),
        .cm_in      (CM),
        .cm_data    (cm_data),
        .inter_rise (inter_rise),
        .inter_fall (inter_fall)
    );

    assign secret_arr = secret;
    assign guess_out  = guess_arr;
    assign byte_ne    = (guess_arr[cidx] != secret_arr[cidx]);

    // Drive enable and data are both flops; the bus never sees decoded state.
    assign CM = reply_active ? reply_byte : 'z;

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:
                if (inter_rise && cm_data == START_BYTE) state_n = ST_RX_DATA;
            ST_RX_DATA:
                if (inter_rise && idx == IDX_LAST) state_n = ST_RX_END;
            ST_RX_END:
                if (inter_rise) state_n = (cm_data == END_BYTE) ? ST_WAIT_RELEASE : ST_IDLE;
            ST_WAIT_RELEASE:
                if (inter_fall) state_n = ST_TURNAROUND;
            ST_TURNAROUND:
                if (timer == TURN_LAST) state_n = ST_COMPARE;
            ST_COMPARE:
                if (timer == CPB_LAST && (byte_ne || cidx == IDX_LAST)) state_n = ST_REPLY;
            ST_REPLY:
                if (timer == HOLD_LAST) state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            idx          <= '0;
            cidx         <= '0;
            timer        <= '0;
            shadow       <= '0;
            guess_arr    <= '0;
            reply_byte   <= '0;
            match        <= 1'b0;
            match_bytes  <= '0;
            guess_valid  <= 1'b0;
            frame_error  <= 1'b0;
            reply_active <= 1'b0;
        end else begin
            guess_valid  <= 1'b0;
            frame_error  <= 1'b0;
            reply_active <= (state_n == ST_REPLY);
            case (state)
                ST_IDLE: begin
                    idx   <= '0;
                    timer <= '0;
                end
                ST_RX_DATA: begin
                    if (inter_rise) begin
                        shadow[idx] <= cm_data;
                        idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end
                end
                ST_RX_END: begin
                    if (inter_rise) begin
                        if (cm_data == END_BYTE) begin
                            guess_arr   <= shadow;
                            guess_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    timer <= '0;
                end
                ST_TURNAROUND: begin
                    cidx  <= '0;
                    timer <= (timer == TURN_LAST) ? '0 : timer + 1'b1;
                end
                ST_COMPARE: begin
                    if (timer == CPB_LAST) begin
                        timer <= '0;
                        if (byte_ne) begin
                            match       <= 1'b0;
                            match_bytes <= MBW'(cidx);
                            reply_byte  <= NO;
                        end else if (cidx == IDX_LAST) begin
                            match       <= 1'b1;
                            match_bytes <= MBW'(CODE_LEN);
                            reply_byte  <= YES;
                        end else begin
                            cidx <= cidx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_REPLY: begin
                    timer <= (timer == HOLD_LAST) ? '0 : timer + 1'b1;
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule
